// File: rtl/cpu_pkg.sv
// Shared types and constants for the processor phase sequencer.
// Holds the FSM state encoding, the latched instruction class, the syscall kind,
// the PC source encoding and the registered strobe bundle.
package cpu_pkg;

    localparam int unsigned ST_W   = 4;
    localparam int unsigned ID_W   = 32;
    localparam int unsigned CODE_W = 32;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_EXEC   = 4'd3,
        ST_MEM    = 4'd4,
        ST_WB     = 4'd5,
        ST_SYS    = 4'd6,
        ST_RETIRE = 4'd7,
        ST_HALT   = 4'd8
    } state_e;

    typedef enum logic [3:0] {
        CL_NOP, CL_ALU, CL_LW, CL_SW, CL_BR, CL_J, CL_JR, CL_JAL, CL_SYS
    } class_e;

    typedef enum logic [1:0] {
        SK_NOP, SK_PRINT, SK_EXIT
    } sys_kind_e;

    typedef enum logic [1:0] {
        PC_INC    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_REG    = 2'd3
    } pc_src_e;

    // Instruction IDs produced by the decoder
    localparam logic [ID_W-1:0] ID_NOP       = ID_W'(0);
    localparam logic [ID_W-1:0] ID_ALU_LAST  = ID_W'(12);
    localparam logic [ID_W-1:0] ID_LW        = ID_W'(13);
    localparam logic [ID_W-1:0] ID_SW        = ID_W'(14);
    localparam logic [ID_W-1:0] ID_BR_FIRST  = ID_W'(15);
    localparam logic [ID_W-1:0] ID_BR_LAST   = ID_W'(20);
    localparam logic [ID_W-1:0] ID_J         = ID_W'(21);
    localparam logic [ID_W-1:0] ID_JR        = ID_W'(22);
    localparam logic [ID_W-1:0] ID_JAL       = ID_W'(23);
    localparam logic [ID_W-1:0] ID_ALU_X0    = ID_W'(24);
    localparam logic [ID_W-1:0] ID_ALU_X1    = ID_W'(25);
    localparam logic [ID_W-1:0] ID_SYSCALL   = ID_W'(26);
    localparam logic [ID_W-1:0] ID_MAX       = ID_SYSCALL;

    // Syscall codes
    localparam logic [CODE_W-1:0] SC_PRINT_INT = CODE_W'(1);
    localparam logic [CODE_W-1:0] SC_EXIT      = CODE_W'(2);
    localparam logic [CODE_W-1:0] SC_READ      = CODE_W'(3);
    localparam logic [CODE_W-1:0] SC_PRINT_4   = CODE_W'(4);
    localparam logic [CODE_W-1:0] SC_PRINT_8   = CODE_W'(8);

    typedef struct packed {
        logic    ir_load;
        logic    alu_en;
        logic    mem_req;
        logic    mem_we;
        logic    mem_sel;
        logic    rf_we;
        logic    rf_link;
        logic    pc_en;
        pc_src_e pc_src;
        logic    sys_print;
    } strobe_t;

    // Map a legal instruction ID onto the class the FSM sequences by
    function automatic class_e id_class(input logic [ID_W-1:0] id);
        if (id == ID_NOP)                                    return CL_NOP;
        if (id <= ID_ALU_LAST || id == ID_ALU_X0 || id == ID_ALU_X1) return CL_ALU;
        if (id == ID_LW)                                     return CL_LW;
        if (id == ID_SW)                                     return CL_SW;
        if (id >= ID_BR_FIRST && id <= ID_BR_LAST)           return CL_BR;
        if (id == ID_J)                                      return CL_J;
        if (id == ID_JR)                                     return CL_JR;
        if (id == ID_JAL)                                    return CL_JAL;
        if (id == ID_SYSCALL)                                return CL_SYS;
        return CL_NOP;
    endfunction

    // Unknown codes behave as a plain retire
    function automatic sys_kind_e sys_kind(input logic [CODE_W-1:0] code);
        if (code == SC_EXIT)                                 return SK_EXIT;
        if (code == SC_PRINT_INT)                            return SK_PRINT;
        if (code >= SC_PRINT_4 && code <= SC_PRINT_8)        return SK_PRINT;
        return SK_NOP;
    endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Bus watchdog: loadable down-counter timing one memory request.
// Ports: clk, reset (sync, active-high); clr reloads the budget; en counts while a
// request is outstanding; ack pauses counting; expire flags the last allowed cycle.
module mem_watchdog
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic ack,
    output logic expire
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;

    // Count holds the remaining cycles after the current one
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= LOAD;
        end else if (en && !ack && cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign expire = en && (cnt_q == '0);

endmodule

// File: rtl/phase_controller.sv
// Multi-cycle phase sequencer: FETCH -> DECODE -> EXEC -> MEM/WB/SYS -> RETIRE.
// Inputs: start, decoded instr_id/sys_code, branch_cond, mem_ack.
// Outputs: registered per-phase strobes (IR, ALU, memory port, register file, PC),
// sticky halted/illegal/bus_err flags, retired-instruction counter, debug state.
module phase_controller
    import cpu_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      instr_id,
    input  logic [31:0]      sys_code,
    input  logic             branch_cond,
    input  logic             mem_ack,
    output logic [ST_W-1:0]  state,
    output logic             ir_load,
    output logic             alu_en,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_sel,
    output logic             rf_we,
    output logic             rf_link,
    output logic             pc_en,
    output logic [1:0]       pc_src,
    output logic             sys_print,
    output logic             halted,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired
);

    state_e     state_q, state_d;
    class_e     class_q, class_d;
    sys_kind_e  sys_q, sys_d;
    logic       br_q, br_d;
    strobe_t    strb_q, strb_d;
    logic       halted_q, halted_d;
    logic       illegal_q, illegal_d;
    logic       bus_err_q, bus_err_d;
    logic [CNT_W-1:0] retired_q;
    logic       in_mem;
    logic       expire;

    assign in_mem = (state_q == ST_FETCH) || (state_q == ST_MEM);

    // Reloaded whenever no request is outstanding, so it is fresh on every FETCH/MEM entry
    mem_watchdog #(.TIMEOUT(MEM_TIMEOUT)) u_wdog (
        .clk    (clk),
        .reset  (reset),
        .clr    (!in_mem),
        .en     (in_mem),
        .ack    (mem_ack),
        .expire (expire)
    );

    // Next state, latched instruction context and sticky flags
    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        sys_d     = sys_q;
        br_d      = br_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        unique case (state_q)
            ST_IDLE:   if (start) state_d = ST_FETCH;
            ST_FETCH: begin
                if (mem_ack) begin
                    state_d = ST_DECODE;
                end else if (expire) begin
                    state_d   = ST_HALT;
                    bus_err_d = 1'b1;
                end
            end
            ST_DECODE: begin
                class_d = id_class(instr_id);
                sys_d   = sys_kind(sys_code);
                br_d    = branch_cond;
                if (instr_id == ID_NOP) begin
                    state_d = ST_RETIRE;
                end else if (instr_id > ID_MAX) begin
                    state_d   = ST_HALT;
                    illegal_d = 1'b1;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                unique case (class_q)
                    CL_ALU, CL_JAL:      state_d = ST_WB;
                    CL_LW, CL_SW:        state_d = ST_MEM;
                    CL_SYS:              state_d = ST_SYS;
                    CL_BR, CL_J, CL_JR:  state_d = ST_FETCH;
                    default:             state_d = ST_RETIRE;
                endcase
            end
            ST_MEM: begin
                if (mem_ack) begin
                    state_d = (class_q == CL_SW) ? ST_RETIRE : ST_WB;
                end else if (expire) begin
                    state_d   = ST_HALT;
                    bus_err_d = 1'b1;
                end
            end
            ST_WB:     state_d = (class_q == CL_JAL) ? ST_FETCH : ST_RETIRE;
            ST_SYS:    state_d = (sys_q == SK_EXIT) ? ST_HALT : ST_RETIRE;
            ST_RETIRE: state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_HALT;
        endcase
        halted_d = halted_q || (state_d == ST_HALT);
    end

    // Strobes decoded from the state being entered so they register alongside it;
    // branch_cond is captured as EXEC is entered so pc_src is stable across EXEC
    always_comb begin
        strb_d = '0;
        unique case (state_d)
            ST_FETCH:  strb_d.mem_req = 1'b1;
            ST_DECODE: strb_d.ir_load = 1'b1;
            ST_EXEC: begin
                strb_d.alu_en = 1'b1;
                unique case (class_d)
                    CL_BR: begin
                        strb_d.pc_en  = 1'b1;
                        strb_d.pc_src = br_d ? PC_BRANCH : PC_INC;
                    end
                    CL_J: begin
                        strb_d.pc_en  = 1'b1;
                        strb_d.pc_src = PC_JUMP;
                    end
                    CL_JR: begin
                        strb_d.pc_en  = 1'b1;
                        strb_d.pc_src = PC_REG;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                strb_d.mem_req = 1'b1;
                strb_d.mem_sel = 1'b1;
                strb_d.mem_we  = (class_d == CL_SW);
            end
            ST_WB: begin
                strb_d.rf_we = 1'b1;
                if (class_d == CL_JAL) begin
                    strb_d.rf_link = 1'b1;
                    strb_d.pc_en   = 1'b1;
                    strb_d.pc_src  = PC_JUMP;
                end
            end
            ST_SYS: begin
                strb_d.sys_print = (sys_d == SK_PRINT);
                strb_d.pc_en     = (sys_d == SK_EXIT);
            end
            ST_RETIRE: strb_d.pc_en = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            class_q   <= CL_NOP;
            sys_q     <= SK_NOP;
            br_q      <= 1'b0;
            strb_q    <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            sys_q     <= sys_d;
            br_q      <= br_d;
            strb_q    <= strb_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            retired_q <= retired_q + CNT_W'(strb_q.pc_en);
        end
    end

    assign state     = state_q;
    assign ir_load   = strb_q.ir_load;
    assign alu_en    = strb_q.alu_en;
    assign mem_req   = strb_q.mem_req;
    assign mem_we    = strb_q.mem_we;
    assign mem_sel   = strb_q.mem_sel;
    assign rf_we     = strb_q.rf_we;
    assign rf_link   = strb_q.rf_link;
    assign pc_en     = strb_q.pc_en;
    assign pc_src    = strb_q.pc_src;
    assign sys_print = strb_q.sys_print;
    assign halted    = halted_q;
    assign illegal   = illegal_q;
    assign bus_err   = bus_err_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_phase_controller.sv
// Self-checking bench for phase_controller: an instruction-level model expands each
// instruction into its expected per-cycle strobe pattern and memory handshake.
module tb_phase_controller;
    import cpu_pkg::*;

    localparam int unsigned TO  = 16;
    localparam int unsigned CW  = 4;

    logic clk, reset, start, branch_cond, mem_ack;
    logic [31:0] instr_id, sys_code;
    logic [3:0]  state;
    logic ir_load, alu_en, mem_req, mem_we, mem_sel, rf_we, rf_link, pc_en, sys_print;
    logic [1:0]  pc_src;
    logic halted, illegal, bus_err;
    logic [CW-1:0] retired;

    phase_controller #(.CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .instr_id(instr_id),
        .sys_code(sys_code), .branch_cond(branch_cond), .mem_ack(mem_ack),
        .state(state), .ir_load(ir_load), .alu_en(alu_en), .mem_req(mem_req),
        .mem_we(mem_we), .mem_sel(mem_sel), .rf_we(rf_we), .rf_link(rf_link),
        .pc_en(pc_en), .pc_src(pc_src), .sys_print(sys_print), .halted(halted),
        .illegal(illegal), .bus_err(bus_err), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] s;
        logic        ack;
        logic [31:0] id;
        logic [31:0] code;
        logic        cond;
    } cyc_t;

    cyc_t        prog[$];
    logic [10:0] obs[$];
    logic [10:0] strobes;
    int          checks, errors;
    int unsigned m_ret;
    bit          m_halt, m_ill, m_bus;
    logic [31:0] cur_id, cur_code;
    bit          cur_cond;

    assign strobes = {ir_load, alu_en, mem_req, mem_we, mem_sel, rf_we, rf_link,
                      pc_en, pc_src, sys_print};

    function automatic logic [10:0] sv(input bit ir, alu, req, we, sel, rfwe, lnk, pce,
                                       input logic [1:0] src, input bit prt);
        return {ir, alu, req, we, sel, rfwe, lnk, pce, src, prt};
    endfunction

    // Memory cycles get the scheduled ack; all others get random ack noise
    task automatic push(input logic [10:0] s, input bit mem_cyc, input bit ack);
        cyc_t c;
        c.s    = s;
        c.ack  = mem_cyc ? ack : 1'($urandom_range(0, 1));
        c.id   = cur_id;
        c.code = cur_code;
        c.cond = cur_cond;
        prog.push_back(c);
    endtask

    // Expand one instruction: df/dm = cycles of waiting before the fetch/data ack
    task automatic add_instr(input int id, input int code, input bit cond,
                             input int df, input int dm);
        bit is_br, is_sw;
        if (m_halt) return;
        cur_id = 32'(id); cur_code = 32'(code); cur_cond = cond;
        if (df >= int'(TO)) begin
            repeat (TO) push(sv(0,0,1,0,0,0,0,0,2'd0,0), 1, 0);
            m_halt = 1; m_bus = 1; return;
        end
        for (int k = 0; k <= df; k++) push(sv(0,0,1,0,0,0,0,0,2'd0,0), 1, k == df);
        push(sv(1,0,0,0,0,0,0,0,2'd0,0), 0, 0);
        if (id == 0) begin push(sv(0,0,0,0,0,0,0,1,2'd0,0), 0, 0); m_ret++; return; end
        if (id > 26) begin m_halt = 1; m_ill = 1; return; end
        is_br = (id >= 15 && id <= 20);
        if (is_br)         push(sv(0,1,0,0,0,0,0,1, cond ? 2'd1 : 2'd0, 0), 0, 0);
        else if (id == 21) push(sv(0,1,0,0,0,0,0,1,2'd2,0), 0, 0);
        else if (id == 22) push(sv(0,1,0,0,0,0,0,1,2'd3,0), 0, 0);
        else               push(sv(0,1,0,0,0,0,0,0,2'd0,0), 0, 0);
        if (is_br || id == 21 || id == 22) begin m_ret++; return; end
        if (id == 13 || id == 14) begin
            is_sw = (id == 14);
            if (dm >= int'(TO)) begin
                repeat (TO) push(sv(0,0,1,is_sw,1,0,0,0,2'd0,0), 1, 0);
                m_halt = 1; m_bus = 1; return;
            end
            for (int k = 0; k <= dm; k++) push(sv(0,0,1,is_sw,1,0,0,0,2'd0,0), 1, k == dm);
            if (is_sw) begin push(sv(0,0,0,0,0,0,0,1,2'd0,0), 0, 0); m_ret++; return; end
        end
        if (id == 23) begin push(sv(0,0,0,0,0,1,1,1,2'd2,0), 0, 0); m_ret++; return; end
        if (id == 26) begin
            if (code == 2) begin
                push(sv(0,0,0,0,0,0,0,1,2'd0,0), 0, 0);
                m_ret++; m_halt = 1; return;
            end
            push(sv(0,0,0,0,0,0,0,0,2'd0, code == 1 || (code >= 4 && code <= 8)), 0, 0);
            push(sv(0,0,0,0,0,0,0,1,2'd0,0), 0, 0);
            m_ret++; return;
        end
        push(sv(0,0,0,0,0,1,0,0,2'd0,0), 0, 0);
        push(sv(0,0,0,0,0,0,0,1,2'd0,0), 0, 0);
        m_ret++;
    endtask

    task automatic add_halt_tail();
        if (m_halt) repeat (4) push(11'd0, 0, 0);
    endtask

    // Leaves the DUT in IDLE with start asserted, just after a falling edge
    task automatic do_reset();
        @(negedge clk);
        reset = 1; start = 1'($urandom_range(0, 1)); mem_ack = 1'($urandom_range(0, 1));
        repeat (2) @(negedge clk);
        reset = 0; start = 1; mem_ack = 0;
        prog.delete(); obs.delete();
        m_ret = 0; m_halt = 0; m_ill = 0; m_bus = 0;
    endtask

    task automatic run_trace(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            obs.push_back(strobes);
            mem_ack = prog[i].ack; instr_id = prog[i].id;
            sys_code = prog[i].code; branch_cond = prog[i].cond;
        end
        @(negedge clk);
        mem_ack = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1; start = 1; mem_ack = 1;
        repeat (2) @(negedge clk);
        checks++; if (strobes !== 11'd0) begin errors++; $display("FAIL reset_strobes got %b want 0", strobes); end
        checks++; if (state !== 4'(ST_IDLE)) begin errors++; $display("FAIL reset_state got %0d want %0d", state, ST_IDLE); end
        checks++; if ({halted, illegal, bus_err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {halted, illegal, bus_err}); end
        checks++; if (retired !== '0) begin errors++; $display("FAIL reset_retired got %0d want 0", retired); end
        reset = 0; start = 0;
        repeat (3) @(negedge clk);
        checks++; if (state !== 4'(ST_IDLE) || mem_req !== 1'b0) begin errors++; $display("FAIL idle_hold state %0d mem_req %b want IDLE 0", state, mem_req); end
    endtask

    task automatic test_alu();
        do_reset();
        add_instr(1, 0, 0, 2, 0);
        add_instr(25, 0, 0, 0, 0);
        run_trace(prog.size());
        for (int i = 0; i < obs.size(); i++) begin
            checks++; if (obs[i] !== prog[i].s) begin errors++; $display("FAIL alu cyc %0d got %b want %b", i, obs[i], prog[i].s); end
        end
        checks++; if (retired !== CW'(m_ret)) begin errors++; $display("FAIL alu_retired got %0d want %0d", retired, CW'(m_ret)); end
    endtask

    task automatic test_branch();
        do_reset();
        add_instr(15, 0, 1, 0, 0);
        add_instr(15, 0, 0, 1, 0);
        add_instr(20, 0, 1, 0, 0);
        add_instr(21, 0, 0, 0, 0);
        add_instr(22, 0, 1, 3, 0);
        run_trace(prog.size());
        for (int i = 0; i < obs.size(); i++) begin
            checks++; if (obs[i] !== prog[i].s) begin errors++; $display("FAIL branch cyc %0d got %b want %b", i, obs[i], prog[i].s); end
        end
        checks++; if (retired !== CW'(m_ret)) begin errors++; $display("FAIL branch_retired got %0d want %0d", retired, CW'(m_ret)); end
    endtask

    task automatic test_mem_jal();
        do_reset();
        add_instr(13, 0, 0, 1, 2);
        add_instr(14, 0, 0, 0, 3);
        add_instr(23, 0, 0, 2, 0);
        add_instr(0, 0, 0, 0, 0);
        add_instr(14, 0, 0, 0, 0);
        run_trace(prog.size());
        for (int i = 0; i < obs.size(); i++) begin
            checks++; if (obs[i] !== prog[i].s) begin errors++; $display("FAIL mem_jal cyc %0d got %b want %b", i, obs[i], prog[i].s); end
        end
        checks++; if (retired !== CW'(m_ret)) begin errors++; $display("FAIL mem_jal_retired got %0d want %0d", retired, CW'(m_ret)); end
    endtask

    task automatic test_sys();
        do_reset();
        add_instr(26, 1, 0, 0, 0);
        add_instr(26, 3, 0, 1, 0);
        add_instr(26, 9, 0, 0, 0);
        add_instr(26, 7, 0, 0, 0);
        add_instr(26, 2, 0, 0, 0);
        add_instr(1, 0, 0, 0, 0);
        add_halt_tail();
        run_trace(prog.size());
        for (int i = 0; i < obs.size(); i++) begin
            checks++; if (obs[i] !== prog[i].s) begin errors++; $display("FAIL sys cyc %0d got %b want %b", i, obs[i], prog[i].s); end
        end
        checks++; if (retired !== CW'(m_ret)) begin errors++; $display("FAIL sys_retired got %0d want %0d", retired, CW'(m_ret)); end
        checks++; if ({halted, illegal, bus_err} !== 3'b100) begin errors++; $display("FAIL sys_flags got %b want 100", {halted, illegal, bus_err}); end
        checks++; if (state !== 4'(ST_HALT)) begin errors++; $display("FAIL sys_state got %0d want %0d", state, ST_HALT); end
    endtask

    task automatic test_faults();
        // Fetch ack on the last allowed cycle, then a fetch that never completes
        do_reset();
        add_instr(1, 0, 0, TO - 1, 0);
        add_instr(2, 0, 0, TO, 0);
        add_halt_tail();
        run_trace(prog.size());
        for (int i = 0; i < obs.size(); i++) begin
            checks++; if (obs[i] !== prog[i].s) begin errors++; $display("FAIL fetch_timeout cyc %0d got %b want %b", i, obs[i], prog[i].s); end
        end
        checks++; if ({halted, illegal, bus_err, retired} !== {m_halt, m_ill, m_bus, CW'(m_ret)}) begin errors++; $display("FAIL fetch_timeout_flags got %b %0d want %b %0d", {halted, illegal, bus_err}, retired, {m_halt, m_ill, m_bus}, CW'(m_ret)); end
        // Data request that never completes
        do_reset();
        add_instr(13, 0, 0, 0, TO);
        add_halt_tail();
        run_trace(prog.size());
        for (int i = 0; i < obs.size(); i++) begin
            checks++; if (obs[i] !== prog[i].s) begin errors++; $display("FAIL mem_timeout cyc %0d got %b want %b", i, obs[i], prog[i].s); end
        end
        checks++; if ({halted, illegal, bus_err} !== 3'b101) begin errors++; $display("FAIL mem_timeout_flags got %b want 101", {halted, illegal, bus_err}); end
        // Illegal instruction ID
        do_reset();
        add_instr(40, 0, 0, 1, 0);
        add_halt_tail();
        run_trace(prog.size());
        for (int i = 0; i < obs.size(); i++) begin
            checks++; if (obs[i] !== prog[i].s) begin errors++; $display("FAIL illegal cyc %0d got %b want %b", i, obs[i], prog[i].s); end
        end
        checks++; if ({halted, illegal, bus_err, retired} !== {3'b110, CW'(0)}) begin errors++; $display("FAIL illegal_flags got %b %0d want 110 0", {halted, illegal, bus_err}, retired); end
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        add_instr(1, 0, 0, 0, 0);
        add_instr(13, 0, 0, 0, 12);
        run_trace(prog.size() - 6);
        checks++; if (mem_req !== 1'b1 || mem_sel !== 1'b1) begin errors++; $display("FAIL pre_reset mem_req %b mem_sel %b want 1 1", mem_req, mem_sel); end
        reset = 1; start = 0; mem_ack = 1;
        @(negedge clk);
        checks++; if (strobes !== 11'd0 || state !== 4'(ST_IDLE)) begin errors++; $display("FAIL mid_reset strobes %b state %0d want 0 IDLE", strobes, state); end
        checks++; if ({halted, illegal, bus_err, retired} !== '0) begin errors++; $display("FAIL mid_reset_flags got %b %0d want 0", {halted, illegal, bus_err}, retired); end
        reset = 0; mem_ack = 0;
    endtask

    task automatic test_random();
        int id, code;
        do_reset();
        for (int n = 0; n < 30; n++) begin
            id   = int'($urandom_range(0, 26));
            code = int'($urandom_range(0, 9));
            if (code == 2) code = 9;
            add_instr(id, code, 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
        end
        run_trace(prog.size());
        for (int i = 0; i < obs.size(); i++) begin
            checks++; if (obs[i] !== prog[i].s) begin errors++; $display("FAIL random cyc %0d got %b want %b", i, obs[i], prog[i].s); end
        end
        checks++; if (retired !== CW'(m_ret)) begin errors++; $display("FAIL random_retired got %0d want %0d", retired, CW'(m_ret)); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL random_halted got %b want 0", halted); end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_time_limit expired");
        $fatal(1);
    end

    initial begin
        checks = 0; errors = 0;
        reset = 1; start = 0; mem_ack = 0; branch_cond = 0;
        instr_id = '0; sys_code = '0; cur_id = '0; cur_code = '0; cur_cond = 0;
        test_reset();
        test_alu();
        test_branch();
        test_mem_jal();
        test_sys();
        test_faults();
        test_reset_mid_mem();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
